// File: rtl/icetap_capture_ctrl.sv
// Capture sequencer for the icetap buffer: arms on start, records into a circular
// BRAM buffer, places the trigger at start/middle/end of the record, drives read-out.
module icetap_capture_ctrl #(
  parameter int unsigned RECORD_DEPTH  = 256,
  parameter int unsigned RAM_ADDR_BITS = $clog2(RECORD_DEPTH)
) (
  input  logic                     src_clk,
  input  logic                     src_reset_,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               trigger_pos,
  input  logic                     store_hit,
  input  logic                     trigger_hit,
  output logic                     wr_ena,
  output logic [RAM_ADDR_BITS-1:0] wr_addr,
  output logic [1:0]               state,
  output logic [RAM_ADDR_BITS-1:0] start_addr,
  output logic [RAM_ADDR_BITS-1:0] trigger_addr,
  output logic [RAM_ADDR_BITS-1:0] stop_addr,
  input  logic                     read_req_first,
  input  logic                     read_req_next,
  output logic [RAM_ADDR_BITS-1:0] rd_addr
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_TRIGGER = 2'd1,
    POST_TRIGGER = 2'd2,
    DONE         = 2'd3
  } state_t;

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = RAM_ADDR_BITS'(1);
  localparam logic [RAM_ADDR_BITS-1:0] POST_MID = RAM_ADDR_BITS'(RECORD_DEPTH / 2);

  state_t                   cur_state, nxt_state;
  logic [RAM_ADDR_BITS-1:0] ptr, ptr_d;
  logic                     wrapped, wrapped_d;
  logic [RAM_ADDR_BITS-1:0] post_cnt, post_cnt_d;
  logic [1:0]               pos, pos_d;
  logic                     wr_ena_d;
  logic [RAM_ADDR_BITS-1:0] wr_addr_d, start_addr_d, trigger_addr_d, stop_addr_d;
  logic [RAM_ADDR_BITS-1:0] post_len;
  logic                     do_wr, finish;

  assign state = cur_state;

  always_comb begin
    case (pos)
      2'd0:    post_len = '1;
      2'd2:    post_len = '0;
      default: post_len = POST_MID;
    endcase
  end

  always_comb begin
    nxt_state      = cur_state;
    ptr_d          = ptr;
    wrapped_d      = wrapped;
    post_cnt_d     = post_cnt;
    pos_d          = pos;
    wr_ena_d       = 1'b0;
    wr_addr_d      = wr_addr;
    start_addr_d   = start_addr;
    trigger_addr_d = trigger_addr;
    stop_addr_d    = stop_addr;
    do_wr          = 1'b0;
    finish         = 1'b0;

    if (abort) begin
      nxt_state = IDLE;
    end else if (start) begin
      nxt_state = WAIT_TRIGGER;
      ptr_d     = '0;
      wrapped_d = 1'b0;
      pos_d     = trigger_pos;
    end else begin
      case (cur_state)
        WAIT_TRIGGER: begin
          do_wr = store_hit | trigger_hit;
          if (trigger_hit) begin
            trigger_addr_d = ptr;
            post_cnt_d     = post_len;
            if (post_len == '0) finish = 1'b1;
            else                nxt_state = POST_TRIGGER;
          end
        end
        POST_TRIGGER: begin
          do_wr = store_hit;
          if (store_hit) begin
            post_cnt_d = post_cnt - ADDR_ONE;
            if (post_cnt == ADDR_ONE) finish = 1'b1;
          end
        end
        default: ;
      endcase

      if (do_wr) begin
        wr_ena_d  = 1'b1;
        wr_addr_d = ptr;
        ptr_d     = ptr + ADDR_ONE;
        wrapped_d = wrapped | (ptr == '1);
      end
      // finish always coincides with a write, so wrapped_d already covers the final wrap
      if (finish) begin
        nxt_state    = DONE;
        stop_addr_d  = ptr;
        start_addr_d = wrapped_d ? ptr + ADDR_ONE : '0;
      end
    end
  end

  always_ff @(posedge src_clk or negedge src_reset_) begin
    if (!src_reset_) begin
      cur_state    <= IDLE;
      ptr          <= '0;
      wrapped      <= 1'b0;
      post_cnt     <= '0;
      pos          <= '0;
      wr_ena       <= 1'b0;
      wr_addr      <= '0;
      start_addr   <= '0;
      trigger_addr <= '0;
      stop_addr    <= '0;
    end else begin
      cur_state    <= nxt_state;
      ptr          <= ptr_d;
      wrapped      <= wrapped_d;
      post_cnt     <= post_cnt_d;
      pos          <= pos_d;
      wr_ena       <= wr_ena_d;
      wr_addr      <= wr_addr_d;
      start_addr   <= start_addr_d;
      trigger_addr <= trigger_addr_d;
      stop_addr    <= stop_addr_d;
    end
  end

  always_ff @(posedge src_clk or negedge src_reset_) begin
    if (!src_reset_)         rd_addr <= '0;
    else if (read_req_first) rd_addr <= start_addr;
    else if (read_req_next)  rd_addr <= rd_addr + ADDR_ONE;
  end

endmodule

// File: tb/tb_icetap_capture_ctrl.sv
// Randomized and directed bench for icetap_capture_ctrl at depth 16, checked against
// a sample-count based reference model.
module tb_icetap_capture_ctrl;

  localparam int unsigned D  = 16;
  localparam int unsigned AW = 4;

  logic          src_clk = 1'b0;
  logic          src_reset_;
  logic          start, abort, store_hit, trigger_hit, read_req_first, read_req_next;
  logic [1:0]    trigger_pos;
  logic          wr_ena;
  logic [AW-1:0] wr_addr, start_addr, trigger_addr, stop_addr, rd_addr;
  logic [1:0]    state;

  always #5 src_clk = ~src_clk;

  icetap_capture_ctrl #(.RECORD_DEPTH(D)) dut (
    .src_clk        (src_clk),
    .src_reset_     (src_reset_),
    .start          (start),
    .abort          (abort),
    .trigger_pos    (trigger_pos),
    .store_hit      (store_hit),
    .trigger_hit    (trigger_hit),
    .wr_ena         (wr_ena),
    .wr_addr        (wr_addr),
    .state          (state),
    .start_addr     (start_addr),
    .trigger_addr   (trigger_addr),
    .stop_addr      (stop_addr),
    .read_req_first (read_req_first),
    .read_req_next  (read_req_next),
    .rd_addr        (rd_addr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: everything derives from the number of samples written since start.
  int m_state, m_count, m_pos, m_left, m_wr_ena, m_wr_addr, m_start, m_trig, m_stop, m_rd;

  function automatic int post_of(input int p);
    if (p == 0) return D - 1;
    if (p == 2) return 0;
    return D / 2;
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_pos = 0; m_left = 0; m_wr_ena = 0;
    m_wr_addr = 0; m_start = 0; m_trig = 0; m_stop = 0; m_rd = 0;
  endtask

  task automatic model_write();
    m_wr_ena  = 1;
    m_wr_addr = m_count % D;
    m_count++;
  endtask

  task automatic model_finish();
    m_stop  = (m_count - 1) % D;
    m_start = (m_count >= D) ? (m_count % D) : 0;
    m_state = 3;
  endtask

  task automatic model_step();
    if (read_req_first)     m_rd = m_start;
    else if (read_req_next) m_rd = (m_rd + 1) % D;
    m_wr_ena = 0;
    if (abort) m_state = 0;
    else if (start) begin
      m_state = 1; m_count = 0; m_pos = int'(trigger_pos);
    end else if (m_state == 1) begin
      if (store_hit || trigger_hit) model_write();
      if (trigger_hit) begin
        m_trig = m_wr_addr;
        m_left = post_of(m_pos);
        if (m_left == 0) model_finish();
        else m_state = 2;
      end
    end else if (m_state == 2 && store_hit) begin
      model_write();
      m_left--;
      if (m_left == 0) model_finish();
    end
  endtask

  task automatic check_all();
    check("state", int'(state), m_state);
    check("wr_ena", int'(wr_ena), m_wr_ena);
    if (m_wr_ena != 0) check("wr_addr", int'(wr_addr), m_wr_addr);
    check("start_addr", int'(start_addr), m_start);
    check("trigger_addr", int'(trigger_addr), m_trig);
    check("stop_addr", int'(stop_addr), m_stop);
    check("rd_addr", int'(rd_addr), m_rd);
  endtask

  task automatic cycle(input bit a, input bit s, input bit [1:0] tp, input bit sh,
                       input bit th, input bit rf, input bit rn);
    abort = a; start = s; trigger_pos = tp; store_hit = sh; trigger_hit = th;
    read_req_first = rf; read_req_next = rn;
    @(posedge src_clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    src_reset_ = 1'b0;
    #2;
    model_reset();
    check_all();
    @(posedge src_clk);
    #1;
    src_reset_ = 1'b1;
  endtask

  initial begin
    src_reset_ = 1'b0;
    start = 0; abort = 0; trigger_pos = 0; store_hit = 0; trigger_hit = 0;
    read_req_first = 0; read_req_next = 0;
    model_reset();
    repeat (2) @(posedge src_clk);
    #1;
    check_all();
    src_reset_ = 1'b1;

    // trigger at end
    cycle(0, 1, 2, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
    check("end_state", int'(state), 3);
    check("end_trig", int'(trigger_addr), 4);
    check("end_stop", int'(stop_addr), 4);
    check("end_start", int'(start_addr), 0);

    // trigger in middle after wrap, then read walk
    cycle(0, 1, 1, 0, 0, 0, 0);
    repeat (20) cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
    check("mid_trig", int'(trigger_addr), 4);
    check("mid_state_post", int'(state), 2);
    repeat (8) cycle(0, 0, 0, 1, 0, 0, 0);
    check("mid_state_done", int'(state), 3);
    check("mid_stop", int'(stop_addr), 12);
    check("mid_start", int'(start_addr), 13);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("rd_first", int'(rd_addr), 13);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("rd_next1", int'(rd_addr), 14);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("rd_next2", int'(rd_addr), 15);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("rd_next3", int'(rd_addr), 0);
    cycle(0, 0, 0, 0, 0, 1, 1);
    check("rd_both", int'(rd_addr), 13);

    // trigger at start: final write wraps the pointer
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("start_trig", int'(trigger_addr), 0);
    repeat (15) cycle(0, 0, 0, 1, 0, 0, 0);
    check("start_stop", int'(stop_addr), 15);
    check("start_start", int'(start_addr), 0);
    check("start_state", int'(state), 3);

    // forced write of a trigger without store_hit
    cycle(0, 1, 2, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0, 0);
    check("forced_wr", int'(wr_ena), 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("forced_wr_once", int'(wr_ena), 0);

    // store_hit toggling after the trigger
    cycle(0, 1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, bit'(i % 2), 0, 0, 0);
    check("toggle_state", int'(state), 3);
    check("toggle_stop", int'(stop_addr), 8);

    // abort and restart
    cycle(0, 1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0);
    check("abort_state", int'(state), 0);
    check("abort_wr", int'(wr_ena), 0);
    cycle(0, 1, 2, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0, 0);
    check("restart_addr", int'(wr_addr), 0);
    cycle(1, 1, 0, 1, 0, 0, 0);
    check("start_abort", int'(state), 0);

    // reset mid-capture
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 1, 0, 1, 0);
    mid_reset();

    for (int i = 0; i < 1500; i++) begin
      bit a, s, sh, th, rf, rn;
      bit [1:0] tp;
      a  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < ((m_state == 0 || m_state == 3) ? 25 : 3));
      tp = 2'($urandom_range(0, 3));
      sh = ($urandom_range(0, 99) < 70);
      th = ($urandom_range(0, 99) < 8);
      rf = ($urandom_range(0, 99) < 10);
      rn = ($urandom_range(0, 99) < 40);
      cycle(a, s, tp, sh, th, rf, rn);
      if (i == 700) mid_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
